mem_loader: RTL and testbench

Upstream feeder for the maxfinder datapath. It accepts a stream of 4-bit words over a valid/ready handshake and writes them sequentially into a 16-entry register-file memory. When the memory is full, it raises mem_valid to the maxfinder controller. A combinational read port, addressed by the datapath's mar, supplies the datapath's din.

---
 rtl/mem_loader.sv | 107 ++++++++++
 tb/tb_mem_loader.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// Sequential fill of a DEPTH x DATA_W flop memory over valid/ready,
// with a combinational read port for the maxfinder datapath.
module mem_loader #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              mem_valid,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              overflow_q, overflow_d;
  logic              we;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    we         = 1'b0;
    in_ready   = 1'b0;
    mem_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d  = FILL;
          wr_ptr_d = '0;
        end
      end
      FILL: begin
        // load pre-empts the handshake so a restart never writes
        in_ready = !load;
        if (load) begin
          wr_ptr_d = '0;
        end else if (in_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        mem_valid = 1'b1;
        if (load) begin
          state_d    = FILL;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
        end else if (in_valid) begin
          overflow_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[wr_ptr_q] = in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      mem_q      <= mem_d;
    end
  end

  assign rd_data  = mem_q[rd_addr];
  assign wr_ptr   = wr_ptr_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: fill, bubbles, overflow,
// restart, read-during-write and async reset.
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] wr_ptr;
  logic       mem_valid;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [3:0] w [16] = '{4'h3, 4'h7, 4'h1, 4'hC,
                          4'h2, 4'h5, 4'h6, 4'h0,
                          4'h8, 4'hB, 4'h4, 4'hD,
                          4'hE, 4'h9, 4'hA, 4'hF};
  logic [3:0] exp_mem [16];

  mem_loader dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_ptr   (wr_ptr),
    .mem_valid(mem_valid),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; in_valid = 1'b0;
    in_data = 4'h0; rd_addr = 4'h0;
    #2;
    checks++;
    if (in_ready !== 1'b0 || mem_valid !== 1'b0 ||
        overflow !== 1'b0 || wr_ptr !== 4'h0) begin
      errors++;
      $display("FAIL reset_outs rdy=%b mv=%b ov=%b ptr=%h req 0,0,0,0",
               in_ready, mem_valid, overflow, wr_ptr);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'h0) begin
        errors++;
        $display("FAIL reset_mem[%0d] got %h req 0", i, rd_data);
      end
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got %b req 0", in_ready);
    end
  endtask

  task automatic test_fill();
    pulse_load();
    checks++;
    if (in_ready !== 1'b1 || wr_ptr !== 4'h0) begin
      errors++;
      $display("FAIL fill_start rdy=%b ptr=%h req 1,0", in_ready, wr_ptr);
    end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = w[i]; #1;
      checks++;
      if (in_ready !== 1'b1 || mem_valid !== 1'b0 ||
          wr_ptr !== 4'(i)) begin
        errors++;
        $display("FAIL fill_beat%0d rdy=%b mv=%b ptr=%h req 1,0,%h",
                 i, in_ready, mem_valid, wr_ptr, 4'(i));
      end
      tick();
      exp_mem[i] = w[i];
    end
    in_valid = 1'b0; #1;
    checks++;
    if (mem_valid !== 1'b1 || wr_ptr !== 4'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill_done mv=%b ptr=%h rdy=%b req 1,0,0",
               mem_valid, wr_ptr, in_ready);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== w[i]) begin
        errors++;
        $display("FAIL fill_rd[%0d] got %h req %h", i, rd_data, w[i]);
      end
    end
  endtask

  task automatic test_overflow();
    in_valid = 1'b1; in_data = 4'hA;
    tick(); tick();
    in_valid = 1'b0; #1;
    checks++;
    if (overflow !== 1'b1 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set ov=%b mv=%b req 1,1", overflow, mem_valid);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== exp_mem[i]) begin
        errors++;
        $display("FAIL ovf_mem[%0d] got %h req %h",
                 i, rd_data, exp_mem[i]);
      end
    end
    load = 1'b1; #1;
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_mv_hold got %b req 1", mem_valid);
    end
    tick();
    load = 1'b0; #1;
    checks++;
    if (overflow !== 1'b0 || mem_valid !== 1'b0 ||
        in_ready !== 1'b1 || wr_ptr !== 4'h0) begin
      errors++;
      $display("FAIL ovf_clear ov=%b mv=%b rdy=%b ptr=%h req 0,0,1,0",
               overflow, mem_valid, in_ready, wr_ptr);
    end
  endtask

  task automatic test_rdw_restart();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = w[i];
      tick();
    end
    rd_addr = 4'h4; in_data = 4'h9; #1;
    checks++;
    if (rd_data !== 4'h2) begin
      errors++;
      $display("FAIL rdw_before got %h req 2", rd_data);
    end
    tick();
    exp_mem[4] = 4'h9;
    checks++;
    if (rd_data !== 4'h9 || wr_ptr !== 4'h5) begin
      errors++;
      $display("FAIL rdw_after rd=%h ptr=%h req 9,5", rd_data, wr_ptr);
    end
    load = 1'b1; in_data = 4'h3; #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL restart_rdy got %b req 0", in_ready);
    end
    tick();
    load = 1'b0; rd_addr = 4'h5; #1;
    checks++;
    if (wr_ptr !== 4'h0 || rd_data !== 4'h5 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart ptr=%h mem5=%h rdy=%b req 0,5,1",
               wr_ptr, rd_data, in_ready);
    end
    in_data = 4'hE;
    tick();
    exp_mem[0] = 4'hE;
    rd_addr = 4'h0; #1;
    checks++;
    if (rd_data !== 4'hE || wr_ptr !== 4'h1) begin
      errors++;
      $display("FAIL restart_wr mem0=%h ptr=%h req e,1", rd_data, wr_ptr);
    end
  endtask

  task automatic test_bubbles();
    int acc;
    acc = 1;
    for (int k = 0; k < 30; k++) begin
      in_valid = (k % 2 == 0);
      in_data  = in_valid ? 4'(k + 7) : 4'h5;
      tick();
      if (k % 2 == 0) begin
        exp_mem[acc] = 4'(k + 7);
        acc++;
      end
      checks++;
      if (wr_ptr !== 4'(acc) || mem_valid !== (acc == 16)) begin
        errors++;
        $display("FAIL bubble%0d ptr=%h mv=%b req %h,%b",
                 k, wr_ptr, mem_valid, 4'(acc), acc == 16);
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== exp_mem[i]) begin
        errors++;
        $display("FAIL bubble_rd[%0d] got %h req %h",
                 i, rd_data, exp_mem[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 4'h1;
    tick();
    in_valid = 1'b0; #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre_ovf got %b req 1", overflow);
    end
    #1 reset = 1'b1; #1;
    checks++;
    if (overflow !== 1'b0 || mem_valid !== 1'b0 || wr_ptr !== 4'h0) begin
      errors++;
      $display("FAIL ar_done ov=%b mv=%b ptr=%h req 0,0,0",
               overflow, mem_valid, wr_ptr);
    end
    tick();
    reset = 1'b0;
    pulse_load();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'hB;
      tick();
    end
    #1 reset = 1'b1; #1;
    checks++;
    if (wr_ptr !== 4'h0 || in_ready !== 1'b0 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_fill ptr=%h rdy=%b mv=%b req 0,0,0",
               wr_ptr, in_ready, mem_valid);
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      checks++;
      if (rd_data !== 4'h0) begin
        errors++;
        $display("FAIL ar_mem[%0d] got %h req 0", i, rd_data);
      end
    end
    tick();
    reset = 1'b0;
    tick(); tick();
    rd_addr = 4'h0; #1;
    checks++;
    if (in_ready !== 1'b0 || wr_ptr !== 4'h0 || rd_data !== 4'h0) begin
      errors++;
      $display("FAIL ar_idle rdy=%b ptr=%h mem0=%h req 0,0,0",
               in_ready, wr_ptr, rd_data);
    end
    in_valid = 1'b0;
    pulse_load();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ar_reload rdy=%b req 1", in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_rdw_restart();
    test_bubbles();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
